multicycle_cu: RTL and testbench
================================

Name: multicycle_cu

Overview:
Parametrised multi-cycle control unit; successor to the single-cycle combinational CU. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready/ack handshakes to instruction and data memory. Adds a memory-wait timeout with a sticky fault state and a retired-instruction counter. Sits between the instruction register/datapath and the memories; drives the same datapath control names as CU plus the sequencing strobes.

Parameters:
OPCODE_W, 5, opcode width
OP_RTYPE, 0, reg-reg ALU opcode
OP_ADDI, 1, immediate ALU opcode
OP_LW, 2, load opcode
OP_SW, 3, store opcode
OP_BEQ, 4, branch-equal opcode
OP_JMP, 5, jump opcode
TIMEOUT, 16, max wait cycles for an ack (0 = timeout disabled)
CNT_W, 16, retired-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  opcode field from instruction register, sampled in DECODE
zero  in  1  ALU zero flag, sampled in EXEC
imem_ack  in  1  instruction memory done
mem_ack  in  1  data memory done
imem_req  out  1  instruction fetch request
IRWrite  out  1  load instruction register
PCWrite  out  1  update PC
Branch  out  1  branch-select strobe
Jump  out  1  jump-select strobe
RegDst  out  1  1 = rd destination
RegWrite  out  1  register file write strobe
MemToReg  out  1  writeback from memory
MemRead  out  1  data memory read request
MemWrite  out  1  data memory write request
ALUsrc  out  1  1 = immediate operand
ExtOp  out  1  1 = sign-extend immediate
illegal_op  out  1  one-cycle pulse on unknown opcode
fault  out  1  sticky timeout fault
state_o  out  3  current state code
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n=0, async): state=RST(0), op_q=0, wait counter=0, retired=0; all outputs 0. rst_n asserted mid-instruction aborts immediately; no partial strobe survives.
- State codes: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. Outputs are Moore (decoded from state and op_q), except PCWrite in EXEC (depends on zero) and the ack-qualified strobes.
- RST -> FETCH unconditionally on the first clock after release.
- FETCH: imem_req=1. On imem_ack: IRWrite=1 and PCWrite=1 in the same cycle, then -> DECODE.
- DECODE: op_q<=opcode.
  - Unknown opcode: illegal_op=1 for this cycle, -> FETCH, not retired.
  - OP_JMP: Jump=1, PCWrite=1, retire, -> FETCH.
  - All other opcodes: -> EXEC.
- EXEC:
  - OP_BEQ: Branch=1, PCWrite=zero, retire, -> FETCH.
  - RTYPE/ADDI: -> WB.
  - LW/SW: -> MEM.
- MEM: LW drives MemRead=1; SW drives MemWrite=1; held until mem_ack. On ack, LW -> WB; SW retires and -> FETCH.
- WB: RegWrite=1 for exactly one cycle, retire, -> FETCH.
- Static decode from op_q, valid DECODE+1 through WB, 0 in RST/FETCH/FAULT:
  - RegDst=1 for RTYPE.
  - ALUsrc=1 for ADDI/LW/SW.
  - ExtOp=1 for ADDI/LW/SW/BEQ.
  - MemToReg=1 for LW.
- Timeout: wait counter clears on entry to FETCH or MEM and increments each cycle without ack. An ack on any of the first TIMEOUT cycles in the state is accepted. If no ack arrives in that window, the next edge -> FAULT. TIMEOUT=0 waits forever.
- FAULT: fault=1 and all strobes 0; the state is left only by reset.
- retired: +1 on each retire event; wraps from 2^CNT_W-1 to 0.
- Acks outside their wait state are ignored. An ack arriving in the same cycle the timeout would fire counts as success.

Test Plan:
- Reset then RTYPE (opcode=0), imem_ack on 1st FETCH cycle -> states 1,2,3,5,1; RegWrite=1 for one cycle in WB with RegDst=1; retired=1.
- LW (opcode=2), mem_ack delayed 3 cycles -> MemRead high 4 cycles; WB has MemToReg=1, ALUsrc=1, ExtOp=1. SW (opcode=3) -> MemWrite high until ack, no WB, retired increments.
- BEQ with zero=1, then zero=0 -> PCWrite=1 with Branch=1, then PCWrite=0 with Branch=1; both retire.
- opcode=7 -> illegal_op pulses once in DECODE, back to FETCH, retired unchanged; opcode=5 -> Jump=PCWrite=1 in DECODE.
- TIMEOUT=16, LW with mem_ack never asserted -> FAULT (state_o=7, fault=1) after 16 MEM cycles; ack on the 16th cycle instead -> normal WB; rst_n low -> state 0, fault 0.
- CNT_W=4, 16 JMPs -> retired wraps to 0; rst_n pulsed low mid-MEM -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, a memory-wait timeout into a sticky FAULT, and a retired counter.
//
// state  | meaning
// RST    | first cycle after reset release
// FETCH  | imem_req asserted, waiting for imem_ack
// DECODE | opcode latched; JMP and illegal opcodes finish here
// EXEC   | ALU cycle; BEQ finishes here
// MEM    | data memory access, waiting for mem_ack
// WB     | register file write, instruction retires
// FAULT  | memory wait timed out; left only by reset
module multicycle_cu #(
  parameter int OPCODE_W = 5,
  parameter int OP_RTYPE = 0,
  parameter int OP_ADDI  = 1,
  parameter int OP_LW    = 2,
  parameter int OP_SW    = 3,
  parameter int OP_BEQ   = 4,
  parameter int OP_JMP   = 5,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ack,
  input  logic                mem_ack,
  output logic                imem_req,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                Branch,
  output logic                Jump,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                MemToReg,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                ALUsrc,
  output logic                ExtOp,
  output logic                illegal_op,
  output logic                fault,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    RST    = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd7
  } state_t;

  localparam logic [OPCODE_W-1:0] C_RTYPE = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] C_ADDI  = OPCODE_W'(OP_ADDI);
  localparam logic [OPCODE_W-1:0] C_LW    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] C_SW    = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] C_BEQ   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] C_JMP   = OPCODE_W'(OP_JMP);

  // waitCnt holds the number of ack-less cycles already spent in the wait state
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              stateQ, stateNext;
  logic [OPCODE_W-1:0] opQ;
  logic [WAIT_W-1:0]   waitCnt;
  logic [CNT_W-1:0]    retiredQ;
  logic                retire;
  logic                waitExpired;
  logic                decodeWindow;

  function automatic logic isKnown(input logic [OPCODE_W-1:0] op);
    return (op == C_RTYPE) || (op == C_ADDI) || (op == C_LW) ||
           (op == C_SW) || (op == C_BEQ) || (op == C_JMP);
  endfunction

  assign waitExpired  = (TIMEOUT != 0) && (waitCnt == WAIT_LAST);
  assign decodeWindow = (stateQ == EXEC) || (stateQ == MEM) || (stateQ == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= RST;
      opQ      <= '0;
      waitCnt  <= '0;
      retiredQ <= '0;
    end else begin
      stateQ <= stateNext;
      if (stateQ == DECODE) opQ <= opcode;
      if ((stateQ == FETCH && !imem_ack) || (stateQ == MEM && !mem_ack))
        waitCnt <= waitCnt + 1'b1;
      else
        waitCnt <= '0;
      if (retire) retiredQ <= retiredQ + 1'b1;
    end
  end

  always_comb begin
    stateNext  = stateQ;
    retire     = 1'b0;
    imem_req   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    illegal_op = 1'b0;
    fault      = 1'b0;

    // opQ is stale in DECODE, so the static decode only opens the cycle after
    RegDst   = decodeWindow && (opQ == C_RTYPE);
    ALUsrc   = decodeWindow && ((opQ == C_ADDI) || (opQ == C_LW) || (opQ == C_SW));
    ExtOp    = decodeWindow && ((opQ == C_ADDI) || (opQ == C_LW) || (opQ == C_SW) ||
                                (opQ == C_BEQ));
    MemToReg = decodeWindow && (opQ == C_LW);

    unique case (stateQ)
      RST: stateNext = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          stateNext = DECODE;
        end else if (waitExpired) begin
          stateNext = FAULT;
        end
      end
      DECODE: begin
        if (opcode == C_JMP) begin
          Jump      = 1'b1;
          PCWrite   = 1'b1;
          retire    = 1'b1;
          stateNext = FETCH;
        end else if (isKnown(opcode)) begin
          stateNext = EXEC;
        end else begin
          illegal_op = 1'b1;
          stateNext  = FETCH;
        end
      end
      EXEC: begin
        if (opQ == C_BEQ) begin
          Branch    = 1'b1;
          PCWrite   = zero;
          retire    = 1'b1;
          stateNext = FETCH;
        end else if ((opQ == C_RTYPE) || (opQ == C_ADDI)) begin
          stateNext = WB;
        end else if ((opQ == C_LW) || (opQ == C_SW)) begin
          stateNext = MEM;
        end else begin
          stateNext = FETCH;
        end
      end
      MEM: begin
        MemRead  = (opQ == C_LW);
        MemWrite = (opQ == C_SW);
        if (mem_ack) begin
          if (opQ == C_LW) begin
            stateNext = WB;
          end else begin
            retire    = 1'b1;
            stateNext = FETCH;
          end
        end else if (waitExpired) begin
          stateNext = FAULT;
        end
      end
      WB: begin
        RegWrite  = 1'b1;
        retire    = 1'b1;
        stateNext = FETCH;
      end
      FAULT: begin
        fault    = 1'b1;
        RegDst   = 1'b0;
        ALUsrc   = 1'b0;
        ExtOp    = 1'b0;
        MemToReg = 1'b0;
      end
      default: stateNext = RST;
    endcase
  end

  assign state_o = stateQ;
  assign retired = retiredQ;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: per-cycle vector table plus hand-written
// timeout, ack-on-last-cycle, counter-wrap and async-reset sequences.
module tb_multicycle_cu;

  localparam int OPCODE_W = 5;
  localparam int CNT_W    = 4;

  localparam logic [13:0] B_IMREQ = 14'h2000;
  localparam logic [13:0] B_IRW   = 14'h1000;
  localparam logic [13:0] B_PCW   = 14'h0800;
  localparam logic [13:0] B_BR    = 14'h0400;
  localparam logic [13:0] B_JMP   = 14'h0200;
  localparam logic [13:0] B_RDST  = 14'h0100;
  localparam logic [13:0] B_RW    = 14'h0080;
  localparam logic [13:0] B_M2R   = 14'h0040;
  localparam logic [13:0] B_MRD   = 14'h0020;
  localparam logic [13:0] B_MWR   = 14'h0010;
  localparam logic [13:0] B_ASRC  = 14'h0008;
  localparam logic [13:0] B_EXT   = 14'h0004;
  localparam logic [13:0] B_ILL   = 14'h0002;
  localparam logic [13:0] B_FLT   = 14'h0001;

  localparam logic [13:0] FACK   = B_IMREQ | B_IRW | B_PCW;
  localparam logic [13:0] LWD    = B_ASRC | B_EXT | B_M2R;
  localparam logic [13:0] SWD    = B_ASRC | B_EXT;
  localparam logic [13:0] STATIC = B_RDST | B_M2R | B_ASRC | B_EXT;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [OPCODE_W-1:0] opcode;
  logic                zero, imem_ack, mem_ack;
  logic                imem_req, IRWrite, PCWrite, Branch, Jump, RegDst, RegWrite;
  logic                MemToReg, MemRead, MemWrite, ALUsrc, ExtOp, illegal_op, fault;
  logic [2:0]          state_o;
  logic [CNT_W-1:0]    retired;
  logic [13:0]         strobes;

  multicycle_cu #(.OPCODE_W(OPCODE_W), .TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .imem_ack(imem_ack), .mem_ack(mem_ack), .imem_req(imem_req),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .Jump(Jump),
    .RegDst(RegDst), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUsrc(ALUsrc), .ExtOp(ExtOp),
    .illegal_op(illegal_op), .fault(fault), .state_o(state_o), .retired(retired)
  );

  assign strobes = {imem_req, IRWrite, PCWrite, Branch, Jump, RegDst, RegWrite,
                    MemToReg, MemRead, MemWrite, ALUsrc, ExtOp, illegal_op, fault};

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic        z;
    logic        ia;
    logic        ma;
    logic [2:0]  st;
    logic [13:0] str;
    logic [3:0]  ret;
  } vec_t;

  int   nCompared   = 0;
  int   nMismatched = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input int op, input int z, input int ia, input int ma,
                              input int st, input logic [13:0] str, input int ret);
    vec_t v;
    v.op  = 5'(op);
    v.z   = 1'(z);
    v.ia  = 1'(ia);
    v.ma  = 1'(ma);
    v.st  = 3'(st);
    v.str = str;
    v.ret = 4'(ret);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called on a falling edge: drive, compare, advance to the next falling edge.
  task automatic applyVec(input vec_t v, input string tag);
    logic [13:0] mask;
    opcode   = v.op;
    zero     = v.z;
    imem_ack = v.ia;
    mem_ack  = v.ma;
    #1;
    mask = (v.st == 3'd2) ? ~STATIC : 14'h3fff;
    chk({tag, ".state"}, 32'(state_o), 32'(v.st));
    chk({tag, ".strobes"}, 32'(strobes & mask), 32'(v.str & mask));
    chk({tag, ".retired"}, 32'(retired), 32'(v.ret));
    @(negedge clk);
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    applyVec(mk(0, 0, 0, 0, 0, 14'h0, 0), "rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    opcode   = '0;
    zero     = 1'b0;
    imem_ack = 1'b0;
    mem_ack  = 1'b0;

    //           op z ia ma st  strobes                    ret
    tbl.push_back(mk(0, 0, 0, 0, 0, 14'h0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, FACK, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 14'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, B_RDST, 0));
    tbl.push_back(mk(0, 0, 0, 0, 5, B_RDST | B_RW, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, B_IMREQ, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, FACK, 1));
    tbl.push_back(mk(2, 0, 0, 0, 2, 14'h0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, LWD, 1));
    tbl.push_back(mk(0, 0, 1, 0, 4, LWD | B_MRD, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4, LWD | B_MRD, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4, LWD | B_MRD, 1));
    tbl.push_back(mk(0, 0, 0, 1, 4, LWD | B_MRD, 1));
    tbl.push_back(mk(0, 0, 0, 0, 5, LWD | B_RW, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, FACK, 2));
    tbl.push_back(mk(3, 0, 0, 0, 2, 14'h0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 3, SWD, 2));
    tbl.push_back(mk(0, 0, 0, 0, 4, SWD | B_MWR, 2));
    tbl.push_back(mk(0, 0, 0, 1, 4, SWD | B_MWR, 2));
    tbl.push_back(mk(0, 0, 1, 0, 1, FACK, 3));
    tbl.push_back(mk(4, 0, 0, 0, 2, 14'h0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 3, B_BR | B_PCW | B_EXT, 3));
    tbl.push_back(mk(0, 0, 1, 0, 1, FACK, 4));
    tbl.push_back(mk(4, 0, 0, 0, 2, 14'h0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 3, B_BR | B_EXT, 4));
    tbl.push_back(mk(0, 0, 1, 0, 1, FACK, 5));
    tbl.push_back(mk(7, 0, 1, 1, 2, B_ILL, 5));
    tbl.push_back(mk(0, 0, 1, 1, 1, FACK, 5));
    tbl.push_back(mk(5, 0, 0, 0, 2, B_JMP | B_PCW, 5));
    tbl.push_back(mk(0, 0, 1, 0, 1, FACK, 6));
    tbl.push_back(mk(1, 0, 0, 0, 2, 14'h0, 6));
    tbl.push_back(mk(0, 0, 0, 0, 3, SWD, 6));
    tbl.push_back(mk(0, 0, 0, 0, 5, SWD | B_RW, 6));
    tbl.push_back(mk(0, 0, 0, 0, 1, B_IMREQ, 7));

    repeat (2) @(negedge clk);
    #1;
    chk("reset.state", 32'(state_o), 32'd0);
    chk("reset.strobes", 32'(strobes), 32'd0);
    chk("reset.retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) applyVec(tbl[i], $sformatf("vec%0d", i));

    // LW whose mem_ack never comes: 16 MEM cycles then FAULT, acks ignored
    applyVec(mk(0, 0, 1, 0, 1, FACK, 7), "to.fetch");
    applyVec(mk(2, 0, 0, 0, 2, 14'h0, 7), "to.decode");
    applyVec(mk(0, 0, 0, 0, 3, LWD, 7), "to.exec");
    for (int k = 1; k <= 16; k++)
      applyVec(mk(0, 0, 0, 0, 4, LWD | B_MRD, 7), $sformatf("to.mem%0d", k));
    applyVec(mk(0, 0, 1, 1, 7, B_FLT, 7), "to.fault1");
    applyVec(mk(0, 0, 1, 1, 7, B_FLT, 7), "to.fault2");
    resetPulse();

    // Ack on the 16th MEM cycle still succeeds
    applyVec(mk(0, 0, 0, 0, 0, 14'h0, 0), "ack16.rst");
    applyVec(mk(0, 0, 1, 0, 1, FACK, 0), "ack16.fetch");
    applyVec(mk(2, 0, 0, 0, 2, 14'h0, 0), "ack16.decode");
    applyVec(mk(0, 0, 0, 0, 3, LWD, 0), "ack16.exec");
    for (int k = 1; k <= 15; k++)
      applyVec(mk(0, 0, 0, 0, 4, LWD | B_MRD, 0), $sformatf("ack16.mem%0d", k));
    applyVec(mk(0, 0, 0, 1, 4, LWD | B_MRD, 0), "ack16.mem16");
    applyVec(mk(0, 0, 0, 0, 5, LWD | B_RW, 0), "ack16.wb");
    applyVec(mk(0, 0, 0, 0, 1, B_IMREQ, 1), "ack16.after");
    resetPulse();

    // 16 JMPs wrap the 4-bit retired counter
    applyVec(mk(0, 0, 0, 0, 0, 14'h0, 0), "wrap.rst");
    for (int j = 1; j <= 16; j++) begin
      applyVec(mk(0, 0, 1, 0, 1, FACK, (j - 1) & 15), $sformatf("wrap.fetch%0d", j));
      applyVec(mk(5, 0, 0, 0, 2, B_JMP | B_PCW, (j - 1) & 15), $sformatf("wrap.jmp%0d", j));
    end
    applyVec(mk(0, 0, 0, 0, 1, B_IMREQ, 0), "wrap.after");

    // Asynchronous reset in the middle of a load's MEM wait
    applyVec(mk(0, 0, 1, 0, 1, FACK, 0), "arst.fetch");
    applyVec(mk(2, 0, 0, 0, 2, 14'h0, 0), "arst.decode");
    applyVec(mk(0, 0, 0, 0, 3, LWD, 0), "arst.exec");
    applyVec(mk(0, 0, 0, 0, 4, LWD | B_MRD, 0), "arst.mem1");
    #1;
    chk("arst.pre.strobes", 32'(strobes), 32'(LWD | B_MRD));
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.state", 32'(state_o), 32'd0);
    chk("arst.strobes", 32'(strobes), 32'd0);
    chk("arst.retired", 32'(retired), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
